uart_tx_sched: RTL

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_fifo.sv | 49 ++++
 rtl/uart_tx_sched.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } drain_state_e;

  // 115200 baud from a 100 MHz clock, stored as clocks-per-bit minus one
  localparam logic [15:0] DEFAULT_BIT_PERIOD = 16'd867;
  localparam int          BUSY_TIMEOUT       = 4;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word-fall-through byte FIFO with occupancy output.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  // A pop frees the slot a full push needs; a push supplies the word an empty pop takes
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && (!empty || push);
  assign rdata   = empty ? wdata : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin byte arbiter feeding a FIFO that is drained into a UART
// transmitter, with deferred application of bit-period changes.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  input  logic [8*NUM_REQ-1:0]        req_data_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  input  logic                        cfg_wr_i,
  input  logic [15:0]                 cfg_bit_period_i,
  output logic                        cfg_pending_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
  output logic                        tx_en_o,
  output logic [7:0]                  tx_data_o,
  input  logic                        tx_busy_i,
  output logic                        wr_bit_period_o,
  output logic [15:0]                 bit_period_o,
  output logic                        idle_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  drain_state_e     state, state_n;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] idx;
  logic [NUM_REQ-1:0] grant;
  logic             found;
  int               sum;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_rdata;
  logic [7:0]       push_data;
  logic [7:0]       tx_data_q;
  logic [2:0]       busy_cnt;
  logic             cfg_pending_q;
  logic [15:0]      bit_period_q;
  logic             cfg_apply;

  // rr_ptr holds the highest-priority index; search wraps from there
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = 0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = int'(rr_ptr) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = IDX_W'(sum);
      if (!found && req_valid_i[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
    if (fifo_full) grant = '0;
  end

  assign req_ready_o = grant;
  assign fifo_push   = |grant;
  assign push_data   = req_data_i[{grant_idx, 3'b000} +: 8];

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (push_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .level (fifo_level_o),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_n         = state;
    fifo_pop        = 1'b0;
    cfg_apply       = 1'b0;
    tx_en_o         = 1'b0;
    wr_bit_period_o = 1'b0;
    case (state)
      ST_IDLE: begin
        // A queued rate change always beats a new byte
        if (cfg_pending_q) begin
          if (!tx_busy_i) begin
            cfg_apply       = 1'b1;
            wr_bit_period_o = 1'b1;
          end
        end else if (!fifo_empty && !tx_busy_i) begin
          fifo_pop = 1'b1;
          state_n  = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        tx_en_o = 1'b1;
        state_n = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (tx_busy_i)                            state_n = ST_WAIT_DONE;
        else if (busy_cnt == 3'(BUSY_TIMEOUT-1))  state_n = ST_LAUNCH;
      end
      ST_WAIT_DONE: begin
        if (!tx_busy_i) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      rr_ptr        <= '0;
      busy_cnt      <= '0;
      tx_data_q     <= 8'h00;
      cfg_pending_q <= 1'b0;
      bit_period_q  <= DEFAULT_BIT_PERIOD;
    end else begin
      state <= state_n;
      if (fifo_push)
        rr_ptr <= (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
      if (state == ST_LAUNCH)         busy_cnt <= '0;
      else if (state == ST_WAIT_BUSY) busy_cnt <= busy_cnt + 1'b1;
      if (fifo_pop) tx_data_q <= fifo_rdata;
      // A write landing on the apply cycle re-arms with the newer value
      if (cfg_wr_i) begin
        cfg_pending_q <= 1'b1;
        bit_period_q  <= cfg_bit_period_i;
      end else if (cfg_apply) begin
        cfg_pending_q <= 1'b0;
      end
    end
  end

  assign tx_data_o     = tx_data_q;
  assign cfg_pending_o = cfg_pending_q;
  assign bit_period_o  = bit_period_q;
  assign idle_o        = fifo_empty && (state == ST_IDLE) && !cfg_pending_q && !tx_busy_i;

endmodule
